// File: rtl/br_local_inject_arbiter_pkg.sv
// rtl/br_local_inject_arbiter_pkg.sv - BrLite flit types and local inject arbiter state encoding
package br_local_inject_arbiter_pkg;

  localparam int BR_ID_W = 5;

  typedef enum logic [1:0] {
    BR_SVC_NONE = 2'd0,
    BR_SVC_TGT  = 2'd1,
    BR_SVC_ALL  = 2'd2,
    BR_SVC_MON  = 2'd3
  } br_svc_t;

  typedef struct packed {
    logic [15:0]        payload;
    logic [15:0]        target;
    logic [15:0]        source;
    br_svc_t            service;
    logic [BR_ID_W-1:0] id;
  } br_data_t;

  typedef enum logic [1:0] {
    BR_ARB_IDLE,
    BR_ARB_SEND,
    BR_ARB_RELEASE
  } br_arb_state_t;

endpackage

// File: rtl/br_rr_arbiter.sv
// rtl/br_rr_arbiter.sv - combinational round-robin pick starting at a rotating pointer
module br_rr_arbiter
  import br_local_inject_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the requesters cyclically from ptr; the first one found wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      if (int'(ptr) + off >= N) begin
        cand = IDX_W'(int'(ptr) + off - N);
      end else begin
        cand = IDX_W'(int'(ptr) + off);
      end
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/br_local_inject_arbiter.sv
// rtl/br_local_inject_arbiter.sv - shares the BrLite router local port among on-tile clients
module br_local_inject_arbiter
  import br_local_inject_arbiter_pkg::*;
#(
  parameter int N_CLI   = 4,
  parameter int ID_INIT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            src_xy_i,
  input  logic [N_CLI-1:0]       cli_req_i,
  input  br_data_t [N_CLI-1:0]   cli_flit_i,
  output logic [N_CLI-1:0]       cli_ack_o,
  input  logic                   busy_i,
  output br_data_t               flit_o,
  output logic                   req_o,
  input  logic                   ack_i,
  output logic [N_CLI-1:0]       grant_o,
  output logic [31:0]            sent_cnt_o
);

  localparam int IDX_W = $clog2(N_CLI);

  br_arb_state_t      state_q, state_d;
  br_data_t           flit_q, flit_d;
  logic               req_q, req_d;
  logic [N_CLI-1:0]   grant_q, grant_d;
  logic [N_CLI-1:0]   ack_q, ack_d;
  logic [N_CLI-1:0]   mask_q, mask_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [BR_ID_W-1:0] id_q, id_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [N_CLI-1:0]   eligible;
  logic [N_CLI-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;

  // The previous owner is masked for one cycle so its still-high req cannot win again.
  assign eligible = cli_req_i & ~mask_q;

  br_rr_arbiter #(.N(N_CLI), .IDX_W(IDX_W)) u_rr (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Next-state and datapath: issue from IDLE, wait for ack in SEND, wait for ack release.
  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    req_d   = req_q;
    grant_d = grant_q;
    ack_d   = '0;
    mask_d  = '0;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      BR_ARB_IDLE: begin
        // A lingering ack from the router blocks issue so the 4-phase handshake stays aligned.
        if (!busy_i && !ack_i && (eligible != '0)) begin
          flit_d        = cli_flit_i[arb_idx];
          flit_d.source = src_xy_i;
          flit_d.id     = id_q;
          req_d         = 1'b1;
          grant_d       = arb_gnt;
          id_d          = id_q + 1'b1;
          ptr_d         = (arb_idx == IDX_W'(N_CLI - 1)) ? '0 : arb_idx + 1'b1;
          state_d       = BR_ARB_SEND;
        end
      end
      BR_ARB_SEND: begin
        if (ack_i) begin
          req_d   = 1'b0;
          ack_d   = grant_q;
          cnt_d   = cnt_q + 32'd1;
          state_d = BR_ARB_RELEASE;
        end
      end
      BR_ARB_RELEASE: begin
        if (!ack_i) begin
          grant_d = '0;
          mask_d  = grant_q;
          state_d = BR_ARB_IDLE;
        end
      end
      default: state_d = BR_ARB_IDLE;
    endcase
  end

  // State register; reset abandons any transfer in flight without acking the client.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BR_ARB_IDLE;
      flit_q  <= '0;
      req_q   <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      id_q    <= BR_ID_W'(ID_INIT);
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      req_q   <= req_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign flit_o     = flit_q;
  assign req_o      = req_q;
  assign grant_o    = grant_q;
  assign cli_ack_o  = ack_q;
  assign sent_cnt_o = cnt_q;

endmodule

// File: tb/tb_br_local_inject_arbiter.sv
// tb/tb_br_local_inject_arbiter.sv - scoreboard bench for the local inject arbiter
module tb_br_local_inject_arbiter;
  import br_local_inject_arbiter_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       src_xy;
  logic [N-1:0]      cli_req;
  br_data_t [N-1:0]  cli_flit;
  logic [N-1:0]      cli_ack;
  logic              busy;
  br_data_t          flit;
  logic              req;
  logic              ack;
  logic [N-1:0]      grant;
  logic [31:0]       sent_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int       cli;
    br_data_t flit;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  br_local_inject_arbiter #(.N_CLI(N), .ID_INIT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_xy_i   (src_xy),
    .cli_req_i  (cli_req),
    .cli_flit_i (cli_flit),
    .cli_ack_o  (cli_ack),
    .busy_i     (busy),
    .flit_o     (flit),
    .req_o      (req),
    .ack_i      (ack),
    .grant_o    (grant),
    .sent_cnt_o (sent_cnt)
  );

  // grant and client ack must never have more than one bit set
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (!$onehot0(grant) || !$onehot0(cli_ack)) begin
        bad++;
        $display("FAIL onehot: grant=%b cli_ack=%b, required zero or one-hot", grant, cli_ack);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic br_data_t exp_flit(input int c, input logic [4:0] id);
    br_data_t f;
    f        = cli_flit[c];
    f.source = src_xy;
    f.id     = id;
    return f;
  endfunction

  function automatic void push_exp(input int c, input int id);
    exp_t e;
    e.cli  = c;
    e.flit = exp_flit(c, 5'(id));
    sb.push_back(e);
  endfunction

  task automatic apply_reset();
    rst_n   = 1'b0;
    cli_req = '0;
    busy    = 1'b0;
    ack     = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Router-side stimulus: wait for req, ack after a delay, hold ack, release; report what was seen.
  task automatic run_transfer(input int ack_delay, input int ack_hold, input bit drop_on_ack,
                              output bit tmo, output int lat, output br_data_t f,
                              output logic [N-1:0] g, output logic [N-1:0] ackv,
                              output int pulses, output bit rel_ok, output logic [N-1:0] g_after);
    tmo = 1'b0; lat = 0; f = '0; g = '0; ackv = '0; pulses = 0; rel_ok = 1'b1; g_after = '0;
    while (!req && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!req) begin
      tmo = 1'b1;
      return;
    end
    f = flit;
    g = grant;
    repeat (ack_delay) begin
      @(posedge clk); #1;
    end
    ack = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (cli_ack != '0) begin
        pulses++;
        ackv |= cli_ack;
        if (drop_on_ack) cli_req &= ~cli_ack;
      end
      if (!req) break;
    end
    if (req) begin
      tmo = 1'b1;
      ack = 1'b0;
      return;
    end
    repeat (ack_hold) begin
      @(posedge clk); #1;
      if (cli_ack != '0) begin
        pulses++;
        ackv |= cli_ack;
      end
      if (req || grant == '0) rel_ok = 1'b0;
    end
    ack = 1'b0;
    @(posedge clk); #1;
    if (cli_ack != '0) pulses++;
    g_after = grant;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req: got=%b exp=0", req); end
    total++; if (grant !== '0) begin bad++; $display("FAIL reset_grant: got=%b exp=0", grant); end
    total++; if (cli_ack !== '0) begin bad++; $display("FAIL reset_cli_ack: got=%b exp=0", cli_ack); end
    total++; if (flit !== '0) begin bad++; $display("FAIL reset_flit: got=%h exp=0", flit); end
    total++; if (sent_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got=%0d exp=0", sent_cnt); end
  endtask

  task automatic test_single();
    bit tmo, rok; int lat, pulses; br_data_t f; logic [N-1:0] g, ackv, ga; exp_t e;
    src_xy      = 16'h0300;
    cli_flit[0] = '{payload: 16'hCAFE, target: 16'h0102, source: 16'hFFFF, service: BR_SVC_TGT, id: 5'h1F};
    cli_req     = 4'b0001;
    push_exp(0, 0);
    run_transfer(3, 0, 1'b1, tmo, lat, f, g, ackv, pulses, rok, ga);
    total++; if (tmo) begin bad++; $display("FAIL single_timeout: got=timeout exp=transfer"); end
    total++; if (lat != 1) begin bad++; $display("FAIL single_latency: got=%0d exp=1", lat); end
    e = sb.pop_front();
    total++; if (f !== e.flit) begin bad++; $display("FAIL single_flit: got=%h exp=%h", f, e.flit); end
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL single_grant: got=%b exp=0001", g); end
    total++; if (pulses != 1 || ackv !== 4'b0001) begin bad++; $display("FAIL single_ack: got=%0d/%b exp=1/0001", pulses, ackv); end
    total++; if (sent_cnt !== 32'd1) begin bad++; $display("FAIL single_cnt: got=%0d exp=1", sent_cnt); end
  endtask

  task automatic test_round_robin();
    bit tmo, rok; int lat, pulses; br_data_t f; logic [N-1:0] g, ackv, ga, prev, oh; exp_t e;
    apply_reset();
    for (int c = 0; c < N; c++)
      cli_flit[c] = '{payload: 16'hA000 + 16'(c), target: 16'h0010 * 16'(c), source: 16'h0, service: BR_SVC_ALL, id: 5'h0};
    for (int i = 0; i < 8; i++) push_exp(i % N, i);
    cli_req = 4'b1111;
    prev    = '0;
    for (int i = 0; i < 8; i++) begin
      run_transfer(0, 0, 1'b0, tmo, lat, f, g, ackv, pulses, rok, ga);
      e  = sb.pop_front();
      oh = 4'b0001 << e.cli;
      total++; if (tmo) begin bad++; $display("FAIL rr_timeout[%0d]: got=timeout exp=transfer", i); end
      total++; if (g !== oh || f !== e.flit) begin bad++; $display("FAIL rr_order[%0d]: got=%b/%h exp=%b/%h", i, g, f, oh, e.flit); end
      total++; if (g === prev) begin bad++; $display("FAIL rr_repeat[%0d]: got=%b exp=differs from previous", i, g); end
      prev = g;
    end
    cli_req = '0;
  endtask

  task automatic test_busy();
    bit tmo, rok, seen; int lat, pulses; br_data_t f; logic [N-1:0] g, ackv, ga; exp_t e;
    apply_reset();
    busy    = 1'b1;
    cli_req = 4'b0110;
    seen    = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (req) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL busy_hold: got=req seen exp=no req"); end
    busy = 1'b0;
    push_exp(1, 0);
    push_exp(2, 1);
    run_transfer(1, 0, 1'b1, tmo, lat, f, g, ackv, pulses, rok, ga);
    e = sb.pop_front();
    total++; if (tmo || lat != 1) begin bad++; $display("FAIL busy_release_latency: got=%0d tmo=%b exp=1", lat, tmo); end
    total++; if (g !== 4'b0010 || f !== e.flit) begin bad++; $display("FAIL busy_first: got=%b/%h exp=0010/%h", g, f, e.flit); end
    run_transfer(0, 0, 1'b1, tmo, lat, f, g, ackv, pulses, rok, ga);
    e = sb.pop_front();
    total++; if (tmo || g !== 4'b0100 || f !== e.flit) begin bad++; $display("FAIL busy_second: got=%b/%h exp=0100/%h", g, f, e.flit); end
    cli_req = '0;
  endtask

  task automatic test_id_wrap();
    bit tmo, rok; int lat, pulses; br_data_t f; logic [N-1:0] g, ackv, ga; exp_t e;
    apply_reset();
    src_xy      = 16'h0507;
    cli_flit[3] = '{payload: 16'h1234, target: 16'h0203, source: 16'h0, service: BR_SVC_MON, id: 5'h0};
    for (int i = 0; i < 40; i++) push_exp(3, i);
    cli_req = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      run_transfer(0, 0, 1'b0, tmo, lat, f, g, ackv, pulses, rok, ga);
      e = sb.pop_front();
      total++; if (tmo || f !== e.flit || g !== 4'b1000) begin bad++; $display("FAIL id_wrap[%0d]: got=id %0d flit %h exp=id %0d flit %h", i, f.id, f, e.flit.id, e.flit); end
    end
    cli_req = '0;
    total++; if (sent_cnt !== 32'd40) begin bad++; $display("FAIL id_wrap_cnt: got=%0d exp=40", sent_cnt); end
  endtask

  task automatic test_reset_mid();
    bit tmo, rok, acked; int lat, pulses, w; br_data_t f; logic [N-1:0] g, ackv, ga; exp_t e;
    apply_reset();
    cli_req = 4'b0001;
    push_exp(0, 0);
    push_exp(0, 1);
    for (int i = 0; i < 2; i++) begin
      run_transfer(0, 0, 1'b0, tmo, lat, f, g, ackv, pulses, rok, ga);
      e = sb.pop_front();
      total++; if (tmo || f !== e.flit) begin bad++; $display("FAIL rstmid_pre[%0d]: got=%h exp=%h", i, f, e.flit); end
    end
    w = 0;
    while (!req && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    total++; if (!req) begin bad++; $display("FAIL rstmid_send: got=req 0 exp=req 1"); end
    rst_n = 1'b0;
    #1;
    total++; if (req !== 1'b0 || grant !== '0 || flit !== '0) begin bad++; $display("FAIL rstmid_clear: got=req %b grant %b flit %h exp=0/0/0", req, grant, flit); end
    acked = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (cli_ack != '0) acked = 1'b1;
    end
    rst_n = 1'b1;
    sb.delete();
    push_exp(0, 0);
    run_transfer(0, 0, 1'b1, tmo, lat, f, g, ackv, pulses, rok, ga);
    e = sb.pop_front();
    total++; if (acked) begin bad++; $display("FAIL rstmid_noack: got=ack pulse exp=none"); end
    total++; if (tmo || f !== e.flit) begin bad++; $display("FAIL rstmid_id: got=%h exp=%h", f, e.flit); end
    total++; if (sent_cnt !== 32'd1) begin bad++; $display("FAIL rstmid_cnt: got=%0d exp=1", sent_cnt); end
  endtask

  task automatic test_drop_mid();
    bit tmo, rok; int lat, pulses, w; br_data_t f; logic [N-1:0] g, ackv, ga; exp_t e;
    apply_reset();
    src_xy      = 16'h0A0B;
    cli_flit[2] = '{payload: 16'hBEEF, target: 16'h0405, source: 16'h7777, service: BR_SVC_TGT, id: 5'h3};
    cli_req     = 4'b0100;
    push_exp(2, 0);
    w = 0;
    while (!req && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    cli_req[2] = 1'b0;
    run_transfer(1, 4, 1'b0, tmo, lat, f, g, ackv, pulses, rok, ga);
    e = sb.pop_front();
    total++; if (tmo || f !== e.flit || g !== 4'b0100) begin bad++; $display("FAIL drop_flit: got=%b/%h exp=0100/%h", g, f, e.flit); end
    total++; if (pulses != 1 || ackv !== 4'b0100) begin bad++; $display("FAIL drop_ack: got=%0d/%b exp=1/0100", pulses, ackv); end
    total++; if (!rok) begin bad++; $display("FAIL drop_release_hold: got=left RELEASE early exp=held"); end
    total++; if (ga !== '0) begin bad++; $display("FAIL drop_release_exit: got=%b exp=0000", ga); end
    total++; if (sent_cnt !== 32'd1) begin bad++; $display("FAIL drop_cnt: got=%0d exp=1", sent_cnt); end
  endtask

  initial begin
    rst_n    = 1'b0;
    src_xy   = 16'h0300;
    cli_req  = '0;
    cli_flit = '0;
    busy     = 1'b0;
    ack      = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy();
    test_id_wrap();
    test_reset_mid();
    test_drop_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
